// File: rtl/t02_mem_request_arbiter_if.sv
// Wishbone-manager side of the t02 memory request arbiter.
// master : arbiter view (drives strobes, address, lane selects, write data)
// slave  : Wishbone manager view (drives busy_o and read data)
//   busy_o     manager busy
//   cpu_dat_o  read data from the manager
//   read_i     one-cycle read start strobe
//   write_i    one-cycle write start strobe
//   adr_i      word-aligned bus address
//   cpu_dat_i  lane-aligned write data
//   sel_i      byte lane select
interface t02_mem_request_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              busy_o;
  logic [DATA_W-1:0] cpu_dat_o;
  logic              read_i;
  logic              write_i;
  logic [ADDR_W-1:0] adr_i;
  logic [DATA_W-1:0] cpu_dat_i;
  logic [3:0]        sel_i;

  modport master (
    input  busy_o, cpu_dat_o,
    output read_i, write_i, adr_i, cpu_dat_i, sel_i
  );

  modport slave (
    output busy_o, cpu_dat_o,
    input  read_i, write_i, adr_i, cpu_dat_i, sel_i
  );
endinterface

// File: rtl/t02_mem_request_arbiter.sv
// t02_mem_request_arbiter: arbitrates CPU instruction-fetch and data
// load/store requests onto single Wishbone-manager transactions. Generates
// byte-lane selects, aligns store data, sign/zero-extends load data and
// traps misaligned data accesses without touching the bus.
// Optional macro T02_REQ_TIMEOUT_EN: aborts a WAIT that exceeds TIMEOUT_CYC
// cycles, pulsing the pending ready with berr=1.
// Ports:
//   CLK, nRST (async, active-low)      clock / reset
//   enable                              low forces IDLE and clears outputs
//   ireq, InstrAddress                  instruction fetch request
//   dread, dwrite, dsize, dunsigned,
//   DataAddress, DatatoWrite            data request (store wins if both)
//   iready, dready                      one-cycle completion pulses
//   dmisalign, berr                     fault flags, pulse with a ready
//   FetchedInstr, FetchedData           results, non-zero only in ready cycle
//   bus                                 Wishbone manager interface (master)
module t02_mem_request_arbiter #(
  parameter int              ADDR_W      = 32,
  parameter int              DATA_W      = 32,
  parameter logic [ADDR_W-1:0] DMEM_BASE = 32'h3300_0000,
  parameter logic [ADDR_W-1:0] IMEM_BASE = 32'h0000_0000,
  parameter int              TIMEOUT_CYC = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              enable,
  input  logic              ireq,
  input  logic [ADDR_W-1:0] InstrAddress,
  input  logic              dread,
  input  logic              dwrite,
  input  logic [1:0]        dsize,
  input  logic              dunsigned,
  input  logic [ADDR_W-1:0] DataAddress,
  input  logic [DATA_W-1:0] DatatoWrite,
  output logic              iready,
  output logic              dready,
  output logic              dmisalign,
  output logic              berr,
  output logic [DATA_W-1:0] FetchedInstr,
  output logic [DATA_W-1:0] FetchedData,
  t02_mem_request_arbiter_if.master bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  logic [1:0]        state_q, state_d;
  logic              is_d_q, is_d_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        a_q, a_d;
  logic              uns_q, uns_d;
  logic              rd_stb_q, rd_stb_d;
  logic              wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [3:0]        sel_q, sel_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic              iready_q, iready_d;
  logic              dready_q, dready_d;
  logic              dmis_q, dmis_d;
  logic              berr_q, berr_d;
  logic [DATA_W-1:0] fi_q, fi_d;
  logic [DATA_W-1:0] fd_q, fd_d;

`ifdef T02_REQ_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 255) ? 16 : 8;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] cnt_q, cnt_d;
`endif

  logic [ADDR_W-1:0] d_addr, i_addr;
  logic [1:0]        lo;
  logic              d_misalign;
  logic [3:0]        d_sel;
  logic [DATA_W-1:0] d_wdat;
  logic [DATA_W-1:0] sh, ld_ext;

  assign d_addr = (DataAddress + DMEM_BASE) & ALIGN_MASK;
  assign i_addr = (InstrAddress + IMEM_BASE) & ALIGN_MASK;
  assign lo     = DataAddress[1:0];

  always_comb begin
    d_misalign = 1'b0;
    d_sel      = 4'b1111;
    d_wdat     = DatatoWrite;
    case (dsize)
      2'b00: begin
        d_sel  = 4'b0001 << lo;
        d_wdat = {4{DatatoWrite[7:0]}};
      end
      2'b01: begin
        d_misalign = lo[0];
        d_sel      = lo[1] ? 4'b1100 : 4'b0011;
        d_wdat     = {2{DatatoWrite[15:0]}};
      end
      default: d_misalign = |lo;
    endcase
  end

  // Load data is shifted down by the latched byte offset before extension.
  assign sh = bus.cpu_dat_o >> {a_q, 3'b000};

  always_comb begin
    case (size_q)
      2'b00:   ld_ext = uns_q ? {{(DATA_W-8){1'b0}}, sh[7:0]}
                              : {{(DATA_W-8){sh[7]}}, sh[7:0]};
      2'b01:   ld_ext = uns_q ? {{(DATA_W-16){1'b0}}, sh[15:0]}
                              : {{(DATA_W-16){sh[15]}}, sh[15:0]};
      default: ld_ext = sh;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    is_d_d   = is_d_q;
    wr_d     = wr_q;
    size_d   = size_q;
    a_d      = a_q;
    uns_d    = uns_q;
    rd_stb_d = 1'b0;
    wr_stb_d = 1'b0;
    adr_d    = adr_q;
    sel_d    = sel_q;
    wdat_d   = wdat_q;
    iready_d = 1'b0;
    dready_d = 1'b0;
    dmis_d   = 1'b0;
    berr_d   = 1'b0;
    fi_d     = '0;
    fd_d     = '0;
`ifdef T02_REQ_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    if (!enable) begin
      state_d = IDLE;
      adr_d   = '0;
      sel_d   = '0;
      wdat_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // The ready-cycle gate guarantees an idle cycle between transactions.
          if (!iready_q && !dready_q) begin
            if (dread || dwrite) begin
              if (d_misalign) begin
                dready_d = 1'b1;
                dmis_d   = 1'b1;
              end else begin
                is_d_d   = 1'b1;
                wr_d     = dwrite;
                size_d   = dsize;
                a_d      = lo;
                uns_d    = dunsigned;
                adr_d    = d_addr;
                sel_d    = d_sel;
                wdat_d   = dwrite ? d_wdat : '0;
                rd_stb_d = ~dwrite;
                wr_stb_d = dwrite;
                state_d  = ISSUE;
              end
            end else if (ireq) begin
              is_d_d   = 1'b0;
              wr_d     = 1'b0;
              size_d   = 2'b10;
              a_d      = 2'b00;
              uns_d    = 1'b0;
              adr_d    = i_addr;
              sel_d    = 4'b1111;
              wdat_d   = '0;
              rd_stb_d = 1'b1;
              state_d  = ISSUE;
            end
          end
        end
        ISSUE: begin
          state_d = WAIT;
`ifdef T02_REQ_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
        WAIT: begin
          if (!bus.busy_o) begin
            if (is_d_q) begin
              dready_d = 1'b1;
              fd_d     = wr_q ? '0 : ld_ext;
            end else begin
              iready_d = 1'b1;
              fi_d     = bus.cpu_dat_o;
            end
            adr_d   = '0;
            sel_d   = '0;
            wdat_d  = '0;
            state_d = IDLE;
          end
`ifdef T02_REQ_TIMEOUT_EN
          else if (cnt_q == TO_LAST) begin
            dready_d = is_d_q;
            iready_d = ~is_d_q;
            berr_d   = 1'b1;
            adr_d    = '0;
            sel_d    = '0;
            wdat_d   = '0;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      is_d_q   <= 1'b0;
      wr_q     <= 1'b0;
      size_q   <= 2'b00;
      a_q      <= 2'b00;
      uns_q    <= 1'b0;
      rd_stb_q <= 1'b0;
      wr_stb_q <= 1'b0;
      adr_q    <= '0;
      sel_q    <= '0;
      wdat_q   <= '0;
      iready_q <= 1'b0;
      dready_q <= 1'b0;
      dmis_q   <= 1'b0;
      berr_q   <= 1'b0;
      fi_q     <= '0;
      fd_q     <= '0;
`ifdef T02_REQ_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      is_d_q   <= is_d_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      a_q      <= a_d;
      uns_q    <= uns_d;
      rd_stb_q <= rd_stb_d;
      wr_stb_q <= wr_stb_d;
      adr_q    <= adr_d;
      sel_q    <= sel_d;
      wdat_q   <= wdat_d;
      iready_q <= iready_d;
      dready_q <= dready_d;
      dmis_q   <= dmis_d;
      berr_q   <= berr_d;
      fi_q     <= fi_d;
      fd_q     <= fd_d;
`ifdef T02_REQ_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign iready        = iready_q;
  assign dready        = dready_q;
  assign dmisalign     = dmis_q;
  assign berr          = berr_q;
  assign FetchedInstr  = fi_q;
  assign FetchedData   = fd_q;
  assign bus.read_i    = rd_stb_q;
  assign bus.write_i   = wr_stb_q;
  assign bus.adr_i     = adr_q;
  assign bus.sel_i     = sel_q;
  assign bus.cpu_dat_i = wdat_q;

endmodule

// File: tb/tb_t02_mem_request_arbiter.sv
module tb_t02_mem_request_arbiter;

  logic        CLK, nRST, enable, ireq, dread, dwrite, dunsigned;
  logic [31:0] InstrAddress, DataAddress, DatatoWrite;
  logic [1:0]  dsize;
  logic        iready, dready, dmisalign, berr;
  logic [31:0] FetchedInstr, FetchedData;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit          wr;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
  } bus_exp_t;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    bit          mis;
    bit          berr;
  } rsp_exp_t;

  bus_exp_t bq[$];
  rsp_exp_t rq[$];

  t02_mem_request_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  t02_mem_request_arbiter #(
    .ADDR_W(32), .DATA_W(32),
    .DMEM_BASE(32'h3300_0000), .IMEM_BASE(32'h0000_0000),
    .TIMEOUT_CYC(4)
  ) dut (
    .CLK(CLK), .nRST(nRST), .enable(enable), .ireq(ireq),
    .InstrAddress(InstrAddress), .dread(dread), .dwrite(dwrite),
    .dsize(dsize), .dunsigned(dunsigned), .DataAddress(DataAddress),
    .DatatoWrite(DatatoWrite), .iready(iready), .dready(dready),
    .dmisalign(dmisalign), .berr(berr), .FetchedInstr(FetchedInstr),
    .FetchedData(FetchedData), .bus(bus_if.master)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_bus(input bit wr, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] wdat);
    bus_exp_t e;
    e.wr = wr; e.adr = adr; e.sel = sel; e.wdat = wdat;
    bq.push_back(e);
  endtask

  task automatic exp_rsp(input bit is_d, input logic [31:0] data, input bit mis, input bit be);
    rsp_exp_t e;
    e.is_d = is_d; e.data = data; e.mis = mis; e.berr = be;
    rq.push_back(e);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_adr"}, bus_if.adr_i, 32'h0);
    chk({tag, "_sel"}, {28'h0, bus_if.sel_i}, 32'h0);
    chk({tag, "_wdat"}, bus_if.cpu_dat_i, 32'h0);
    chk({tag, "_ctrl"}, {26'h0, iready, dready, dmisalign, berr, bus_if.read_i, bus_if.write_i}, 32'h0);
    chk({tag, "_fetched"}, FetchedData | FetchedInstr, 32'h0);
  endtask

  // Bus and response monitor: pops expectations whenever the DUT presents output.
  always @(negedge CLK) begin
    if (nRST) begin
      if (bus_if.read_i || bus_if.write_i) begin
        if (bq.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_strobe: got read=%b write=%b expected none", bus_if.read_i, bus_if.write_i);
        end else begin
          bus_exp_t b;
          b = bq.pop_front();
          chk("bus_write", {31'h0, bus_if.write_i}, {31'h0, b.wr});
          chk("bus_read", {31'h0, bus_if.read_i}, {31'h0, ~b.wr});
          chk("bus_adr", bus_if.adr_i, b.adr);
          chk("bus_sel", {28'h0, bus_if.sel_i}, {28'h0, b.sel});
          chk("bus_wdat", bus_if.cpu_dat_i, b.wdat);
        end
      end
      if (iready || dready) begin
        if (rq.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_ready: got iready=%b dready=%b expected none", iready, dready);
        end else begin
          rsp_exp_t r;
          r = rq.pop_front();
          chk("rsp_dready", {31'h0, dready}, {31'h0, r.is_d});
          chk("rsp_iready", {31'h0, iready}, {31'h0, ~r.is_d});
          chk("rsp_data", r.is_d ? FetchedData : FetchedInstr, r.data);
          chk("rsp_other_zero", r.is_d ? FetchedInstr : FetchedData, 32'h0);
          chk("rsp_dmisalign", {31'h0, dmisalign}, {31'h0, r.mis});
          chk("rsp_berr", {31'h0, berr}, {31'h0, r.berr});
        end
      end
    end
  end

  // Called just after a rising edge; returns one cycle after the ready pulse.
  task automatic run_req(input bit is_i, input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                         input int busy, input int exp_lat, input bit mis);
    int n;
    if (is_i) begin
      ireq = 1'b1; InstrAddress = addr;
    end else begin
      dread = ~wr; dwrite = wr; dsize = sz; dunsigned = uns;
      DataAddress = addr; DatatoWrite = wd;
    end
    bus_if.cpu_dat_o = rd;
    bus_if.busy_o = 1'b1;
    @(posedge CLK); #1;
    ireq = 1'b0; dread = 1'b0; dwrite = 1'b0;
    if (mis) begin
      chk("misalign_dready", {31'h0, dready}, 32'h1);
      chk("misalign_flag", {31'h0, dmisalign}, 32'h1);
      chk("misalign_no_strobe", {31'h0, bus_if.read_i | bus_if.write_i}, 32'h0);
      @(posedge CLK); #1;
      return;
    end
    chk("strobe_timing", {31'h0, bus_if.read_i | bus_if.write_i}, 32'h1);
    @(posedge CLK); #1;
    chk("issue_one_cycle", {31'h0, bus_if.read_i | bus_if.write_i}, 32'h0);
    bus_if.busy_o = (busy > 0);
    for (n = 1; n <= 60; n++) begin
      @(posedge CLK); #1;
      if (iready || dready) break;
      bus_if.busy_o = (n < busy);
    end
    chk("ready_latency", n, exp_lat);
    bus_if.busy_o = 1'b0;
    @(posedge CLK); #1;
  endtask

  initial begin
    int n;
    nRST = 1'b0; enable = 1'b1; ireq = 1'b0; dread = 1'b0; dwrite = 1'b0;
    dsize = 2'b10; dunsigned = 1'b0; InstrAddress = '0; DataAddress = '0; DatatoWrite = '0;
    bus_if.busy_o = 1'b0; bus_if.cpu_dat_o = '0;
    #2;
    all_zero("reset");
    @(posedge CLK); @(posedge CLK); #1;
    nRST = 1'b1;
    @(posedge CLK); #1;

    // word load, two busy cycles -> ready at N+5
    exp_bus(0, 32'h3300_0010, 4'b1111, 32'h0); exp_rsp(1, 32'hDEAD_BEEF, 0, 0);
    run_req(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 2, 3, 0);
    // LB / LBU at 0x13
    exp_bus(0, 32'h3300_0010, 4'b1000, 32'h0); exp_rsp(1, 32'hFFFF_FF80, 0, 0);
    run_req(0, 0, 2'b00, 0, 32'h13, 32'h0, 32'h80FF_FF7F, 0, 1, 0);
    exp_bus(0, 32'h3300_0010, 4'b1000, 32'h0); exp_rsp(1, 32'h0000_0080, 0, 0);
    run_req(0, 0, 2'b00, 1, 32'h13, 32'h0, 32'h80FF_FF7F, 1, 2, 0);
    // SH at 0x22
    exp_bus(1, 32'h3300_0020, 4'b1100, 32'hABCD_ABCD); exp_rsp(1, 32'h0, 0, 0);
    run_req(0, 1, 2'b01, 0, 32'h22, 32'h1234_ABCD, 32'h5555_5555, 0, 1, 0);
    // SB at 0x01
    exp_bus(1, 32'h3300_0000, 4'b0010, 32'hA5A5_A5A5); exp_rsp(1, 32'h0, 0, 0);
    run_req(0, 1, 2'b00, 0, 32'h01, 32'h0000_00A5, 32'h0, 1, 2, 0);
    // LH at 0x06 (sign) and LHU at 0x00
    exp_bus(0, 32'h3300_0004, 4'b1100, 32'h0); exp_rsp(1, 32'hFFFF_8001, 0, 0);
    run_req(0, 0, 2'b01, 0, 32'h06, 32'h0, 32'h8001_1234, 0, 1, 0);
    exp_bus(0, 32'h3300_0000, 4'b0011, 32'h0); exp_rsp(1, 32'h0000_F00D, 0, 0);
    run_req(0, 0, 2'b01, 1, 32'h00, 32'h0, 32'h1234_F00D, 0, 1, 0);
    // SW at 0x40, dsize=11 load at 0x14
    exp_bus(1, 32'h3300_0040, 4'b1111, 32'hCAFE_BABE); exp_rsp(1, 32'h0, 0, 0);
    run_req(0, 1, 2'b10, 0, 32'h40, 32'hCAFE_BABE, 32'h0, 3, 4, 0);
    exp_bus(0, 32'h3300_0014, 4'b1111, 32'h0); exp_rsp(1, 32'h0F0F_0F0F, 0, 0);
    run_req(0, 0, 2'b11, 0, 32'h14, 32'h0, 32'h0F0F_0F0F, 0, 1, 0);
    // instruction fetch
    exp_bus(0, 32'h0000_0100, 4'b1111, 32'h0); exp_rsp(0, 32'h0011_2233, 0, 0);
    run_req(1, 0, 2'b00, 0, 32'h100, 32'h0, 32'h0011_2233, 1, 2, 0);
    // misaligned word load and half store
    exp_rsp(1, 32'h0, 1, 0);
    run_req(0, 0, 2'b10, 0, 32'h02, 32'h0, 32'h0, 0, 0, 1);
    exp_rsp(1, 32'h0, 1, 0);
    run_req(0, 1, 2'b01, 0, 32'h05, 32'hFFFF_FFFF, 32'h0, 0, 0, 1);

    // simultaneous ireq + dread: data first, one idle cycle, then fetch
    exp_bus(0, 32'h3300_0008, 4'b1111, 32'h0); exp_rsp(1, 32'hA5A5_0001, 0, 0);
    exp_bus(0, 32'h0000_0200, 4'b1111, 32'h0); exp_rsp(0, 32'hA5A5_0001, 0, 0);
    ireq = 1'b1; InstrAddress = 32'h200; dread = 1'b1; dsize = 2'b10;
    DataAddress = 32'h8; bus_if.cpu_dat_o = 32'hA5A5_0001; bus_if.busy_o = 1'b0;
    @(posedge CLK); #1;
    dread = 1'b0;
    for (n = 1; n <= 20; n++) begin @(posedge CLK); #1; if (dready) break; end
    chk("arb_data_latency", n, 2);
    for (n = 1; n <= 20; n++) begin @(posedge CLK); #1; if (bus_if.read_i) break; end
    chk("arb_idle_gap", n, 2);
    ireq = 1'b0;
    for (n = 1; n <= 20; n++) begin @(posedge CLK); #1; if (iready) break; end
    chk("arb_fetch_latency", n, 2);
    @(posedge CLK); #1;

    // enable dropped in WAIT: abandoned, cleared, no ready
    exp_bus(0, 32'h0000_0300, 4'b1111, 32'h0);
    ireq = 1'b1; InstrAddress = 32'h300; bus_if.busy_o = 1'b1;
    @(posedge CLK); #1;
    ireq = 1'b0;
    @(posedge CLK); #1;
    enable = 1'b0;
    @(posedge CLK); #1;
    chk("abort_adr", bus_if.adr_i, 32'h0);
    chk("abort_sel", {28'h0, bus_if.sel_i}, 32'h0);
    bus_if.busy_o = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    enable = 1'b1;
    @(posedge CLK); #1;

    // asynchronous reset during ISSUE
    dwrite = 1'b1; dsize = 2'b10; DataAddress = 32'h44; DatatoWrite = 32'h1111_2222;
    bus_if.busy_o = 1'b1;
    @(posedge CLK); #2;
    dwrite = 1'b0;
    nRST = 1'b0;
    #1;
    all_zero("midreset");
    @(posedge CLK); #1;
    nRST = 1'b1;
    bus_if.busy_o = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

`ifdef T02_REQ_TIMEOUT_EN
    exp_bus(0, 32'h0000_0400, 4'b1111, 32'h0); exp_rsp(0, 32'h0, 0, 1);
    run_req(1, 0, 2'b00, 0, 32'h400, 32'h0, 32'hFFFF_FFFF, 100, 4, 0);
`endif

    repeat (3) @(posedge CLK);
    #1;
    chk("bus_queue_empty", bq.size(), 32'h0);
    chk("rsp_queue_empty", rq.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/t02_mem_request_arbiter.md
# t02_mem_request_arbiter

Parametrised successor to the team_02 CPU request unit. It arbitrates between the CPU's instruction-fetch port and its data load/store port, then issues single transactions to the Wishbone manager. It generates byte-lane selects for byte and halfword accesses, aligns store data and sign/zero-extends load data. It also traps misaligned data accesses and, optionally, aborts bus transactions that hang.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; fixed at 32 (4 byte lanes)
- DMEM_BASE, 32'h3300_0000, offset added to every data address
- IMEM_BASE, 32'h0000_0000, offset added to every instruction address
- TIMEOUT_CYC, 255, WAIT-state cycle limit; only used with the timeout macro

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- enable  in  1  unit enable; low forces IDLE
- ireq  in  1  instruction fetch request (level)
- InstrAddress  in  ADDR_W  fetch address
- dread, dwrite  in  1 each  load / store request (level); both high is treated as a store
- dsize  in  2  00 byte, 01 half, 10 word, 11 treated as word
- dunsigned  in  1  zero-extend loads (LBU/LHU)
- DataAddress  in  ADDR_W  data byte address
- DatatoWrite  in  DATA_W  store data, right-justified
- iready, dready  out  1  one-cycle completion pulses
- dmisalign  out  1  pulses with dready on a misaligned data access
- berr  out  1  pulses with iready/dready on a timeout abort
- FetchedInstr, FetchedData  out  DATA_W  result; valid only in the ready cycle, 0 otherwise
- busy_o  in  1  Wishbone manager busy
- cpu_dat_o  in  DATA_W  read data from the manager
- read_i, write_i  out  1  one-cycle transaction start strobes
- adr_i  out  ADDR_W  word-aligned bus address
- cpu_dat_i  out  DATA_W  lane-aligned write data
- sel_i  out  4  byte lane select

## Operation
- States: IDLE, ISSUE, WAIT.
- **IDLE: arbitration.** A request is accepted only if enable=1 and iready=0 and dready=0 in that cycle.
  - A data request beats an instruction request.
  - The request is latched, and its type, size, address low bits and signedness are kept for the transaction.
- **IDLE: misaligned data access.** A half access with addr[0]=1, or a word access with addr[1:0]≠0, is misaligned.
  - No bus transaction is issued and the unit stays in IDLE.
  - dready=1 and dmisalign=1 in the next cycle; FetchedData=0.
- **Address.**
  - Data: adr_i = (DataAddress+DMEM_BASE) with [1:0] forced to 0.
  - Instruction: adr_i = (InstrAddress+IMEM_BASE) with [1:0] forced to 0; instructions are always sel_i=4'b1111.
- **Byte-lane select.**
  - Byte: sel_i = 4'b0001<<a[1:0].
  - Half: sel_i = a[1] ? 4'b1100 : 4'b0011.
  - Word: sel_i = 4'b1111.
- **Store data.** Byte: cpu_dat_i = {4{d[7:0]}}; half: {2{d[15:0]}}; word: d.
- **ISSUE.** Exactly one cycle. read_i or write_i =1; adr_i, sel_i and cpu_dat_i are valid. Next state is WAIT.
- **WAIT.** adr_i, sel_i and cpu_dat_i are held; strobes are 0. The first cycle with busy_o=0 completes the transaction:
  - Load/fetch captures cpu_dat_o >> (8·a[1:0]), then extends it: byte from bit 7, half from bit 15, or zero if dunsigned. Instructions are captured unshifted.
  - The matching ready pulses next cycle.
  - adr_i, sel_i and cpu_dat_i are cleared to 0. Next state is IDLE.
- **Store completion.** dready pulses; FetchedData=0.
- **enable=0 in any state.** The unit goes to IDLE at the next edge, all outputs are 0 and no ready pulse is produced. An in-flight bus cycle is abandoned.
- **Reset.** nRST low mid-transaction takes effect immediately: state IDLE and every output 0.

## Timing
- Reset values: every output is 0, including sel_i=0.
- Request seen in IDLE at edge N:
  - strobe high in cycle N+1;
  - WAIT from N+2;
  - with busy_o=0 at N+2, ready high in N+3.
- Minimum bus latency is 3 cycles; each additional busy cycle adds 1.
- Misaligned access: dready/dmisalign in cycle N+1.
- Back-to-back requests: because of the ready-cycle gate, there is at least one IDLE cycle between transactions.
- Simultaneous ireq and data request: data is served first and ireq is served on the next accepted IDLE cycle.

## Configuration
- T02_REQ_TIMEOUT_EN defined:
  - An 8..16-bit counter runs in WAIT.
  - When busy_o is still 1 after TIMEOUT_CYC WAIT cycles, the unit returns to IDLE.
  - It pulses the pending ready together with berr=1; Fetched* is 0.
- T02_REQ_TIMEOUT_EN undefined: berr is tied to 0 and WAIT lasts until busy_o=0.

## Test plan
- Word load: DataAddress=0x10, dread=1, busy_o high for 2 cycles → write_i=0, read_i pulse, adr_i=0x3300_0010, sel_i=1111; with cpu_dat_o=0xDEADBEEF, dready and FetchedData=0xDEADBEEF at cycle N+5.
- Byte loads: address 0x13, cpu_dat_o=0x80FF_FF7F.
  - LB → sel_i=1000, FetchedData=0xFFFF_FF80.
  - LBU → FetchedData=0x0000_0080.
- Half store: address 0x22, data 0x1234ABCD → sel_i=1100, cpu_dat_i=0xABCD_ABCD, write_i one cycle, dready with FetchedData=0.
- Arbitration and misalignment:
  - ireq=1 and dread=1 together → data served first, then the fetch, with one idle cycle between them.
  - Word load at 0x2 → dready+dmisalign in cycle N+1, with no read_i.
- Abort: enable dropped in WAIT → IDLE at the next edge, adr_i=0, no ready pulse.
- Timeout, with T02_REQ_TIMEOUT_EN defined and TIMEOUT_CYC=4: busy_o held high → iready and berr after 4 WAIT cycles, FetchedInstr=0.
